// File: rtl/ty_stream_pkg.sv
// Shared stream geometry for the Coriolis kernel datapath: element width,
// stream/vector counts and the derived lane index type.
package ty_stream_pkg;

  localparam int unsigned TY_DATA_W   = 32;
  localparam int unsigned TY_NSTREAMS = 4;
  localparam int unsigned TY_GVECT    = 2;
  localparam int unsigned TY_LANES    = TY_NSTREAMS * TY_GVECT;

  // Index width for a count of n, never narrower than one bit.
  function automatic int unsigned ty_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TY_LANE_IDX_W = ty_idx_w(TY_LANES);

  typedef logic [TY_LANE_IDX_W-1:0] ty_lane_idx_t;
  typedef logic [TY_DATA_W-1:0]     ty_elem_t;

endpackage

// File: rtl/ty_lane_packer_if.sv
// Word-serial input stream plus packed-vector output stream of the lane packer.
interface ty_lane_packer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 256
);
  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;
  logic              s_tready;
  logic              m_tvalid;
  logic [OUT_W-1:0]  m_tdata;
  logic              m_tlast;
  logic              m_tready;

  // Host side: sources scalars and sinks packed beats.
  modport master (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );

  // Packer side.
  modport slave (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/ty_axis_oreg.sv
// Single-entry AXI-stream output register: holds data while stalled, allows a
// same-cycle drain and reload, and counts accepted beats.
module ty_axis_oreg #(
  parameter int unsigned W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last,
  output logic [31:0]  beat_cnt
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;
  logic [31:0]  beat_cnt_q, beat_cnt_d;
  logic         drain;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    drain      = valid_q && ready;
    if (drain) begin
      valid_d    = 1'b0;
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
    // The packer only loads when the register is empty or draining this cycle.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign valid    = valid_q;
  assign data     = data_q;
  assign last     = last_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: rtl/ty_lane_packer.sv
// Packs a word-serial scalar stream into LANES-wide vector beats for the
// kernel wrapper; short frames are zero-padded and flagged on err_short.
module ty_lane_packer
  import ty_stream_pkg::*;
#(
  parameter int unsigned DATA_W   = TY_DATA_W,
  parameter int unsigned NSTREAMS = TY_NSTREAMS,
  parameter int unsigned GVECT    = TY_GVECT,
  parameter int unsigned OUT_W    = DATA_W * NSTREAMS * GVECT
) (
  input  logic                aclk,
  input  logic                aresetn,
  ty_lane_packer_if.slave     bus,
  output logic                err_short,
  output logic [31:0]         beat_cnt
);

  localparam int unsigned LANES  = NSTREAMS * GVECT;
  localparam int unsigned LANE_W = ty_idx_w(LANES);

  logic [LANE_W-1:0]             lane_cnt_q, lane_cnt_d;
  logic [LANES-1:0][DATA_W-1:0]  acc_q, acc_d;
  logic                          err_short_q, err_short_d;
  logic [LANES-1:0][DATA_W-1:0]  load_data_c;
  logic                          lane_last_c;
  logic                          closing_c;
  logic                          in_fire_c;
  logic                          load_c;

  // Only a closing word needs the output register, so only it can be stalled.
  always_comb begin
    lane_last_c  = (lane_cnt_q == LANE_W'(LANES - 1));
    closing_c    = lane_last_c || bus.s_tlast;
    bus.s_tready = aresetn && !(bus.m_tvalid && !bus.m_tready && closing_c);
    in_fire_c    = bus.s_tvalid && bus.s_tready;
    load_c       = in_fire_c && closing_c;
  end

  // Lanes below lane_cnt come from acc, the current word fills lane_cnt, rest zero.
  always_comb begin
    load_data_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (LANE_W'(k) < lane_cnt_q) begin
        load_data_c[k] = acc_q[k];
      end else if (LANE_W'(k) == lane_cnt_q) begin
        load_data_c[k] = bus.s_tdata;
      end
    end
  end

  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    acc_d       = acc_q;
    err_short_d = load_c && !lane_last_c;
    if (load_c) begin
      lane_cnt_d = '0;
    end else if (in_fire_c) begin
      acc_d[lane_cnt_q] = bus.s_tdata;
      lane_cnt_d        = lane_cnt_q + LANE_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lane_cnt_q  <= '0;
      acc_q       <= '0;
      err_short_q <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      acc_q       <= acc_d;
      err_short_q <= err_short_d;
    end
  end

  assign err_short = err_short_q;

  ty_axis_oreg #(
    .W (OUT_W)
  ) u_oreg (
    .clk       (aclk),
    .rst_n     (aresetn),
    .load      (load_c),
    .load_data (OUT_W'(load_data_c)),
    .load_last (bus.s_tlast),
    .ready     (bus.m_tready),
    .valid     (bus.m_tvalid),
    .data      (bus.m_tdata),
    .last      (bus.m_tlast),
    .beat_cnt  (beat_cnt)
  );

endmodule

// File: tb/tb_ty_lane_packer.sv
// Directed self-checking bench for ty_lane_packer at default geometry (8 lanes).
module tb_ty_lane_packer;

  logic        aclk;
  logic        aresetn;
  logic        err_short;
  logic [31:0] beat_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stalls = 0;
  bit tog_en = 1'b0;

  logic [255:0] beat_q[$];
  logic         last_q[$];
  int           cyc_q[$];

  ty_lane_packer_if #(.DATA_W(32), .OUT_W(256)) bus ();

  ty_lane_packer dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .err_short (err_short),
    .beat_cnt  (beat_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // A beat sampled valid&&ready at negedge transfers on the next rising edge.
  always @(negedge aclk) begin
    if (aresetn && bus.m_tvalid && bus.m_tready) begin
      beat_q.push_back(bus.m_tdata);
      last_q.push_back(bus.m_tlast);
      cyc_q.push_back(cyc);
    end
  end

  always @(posedge aclk) begin
    if (tog_en) begin
      #1 bus.m_tready = ~bus.m_tready;
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    @(negedge aclk);
    while (!bus.s_tready && n < 50) begin
      n++;
      @(negedge aclk);
    end
    if (n > 0) stalls++;
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout word=%h not accepted within 50 cycles", d);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic clear_mon();
    beat_q.delete(); last_q.delete(); cyc_q.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.s_tlast = 1'b0; bus.m_tready = 1'b0;
    repeat (2) @(negedge aclk);
    checks++; if (bus.s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got=%b exp=0", bus.s_tready); end
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got=%b exp=0", bus.m_tvalid); end
    checks++; if (bus.m_tdata !== 256'd0) begin errors++; $display("FAIL rst_m_tdata got=%h exp=0", bus.m_tdata); end
    checks++; if (bus.m_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast got=%b exp=0", bus.m_tlast); end
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL rst_err_short got=%b exp=0", err_short); end
    checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL rst_beat_cnt got=%0d exp=0", beat_cnt); end
    aresetn = 1'b1;
    #1;
    checks++; if (bus.s_tready !== 1'b1) begin errors++; $display("FAIL rst_release_s_tready got=%b exp=1", bus.s_tready); end
    @(posedge aclk); #1;
  endtask

  task automatic test_full_frame();
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(k + 1);
    bus.m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
    checks++; if (bus.m_tvalid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", bus.m_tvalid); end
    checks++; if (bus.m_tdata !== exp) begin errors++; $display("FAIL full_data got=%h exp=%h", bus.m_tdata, exp); end
    checks++; if (bus.m_tlast !== 1'b1) begin errors++; $display("FAIL full_last got=%b exp=1", bus.m_tlast); end
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL full_err_short got=%b exp=0", err_short); end
    idle();
    @(posedge aclk); #1;
    checks++; if (beat_cnt !== 32'd1) begin errors++; $display("FAIL full_beat_cnt got=%0d exp=1", beat_cnt); end
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL full_drained got=%b exp=0", bus.m_tvalid); end
  endtask

  task automatic test_backpressure();
    logic [255:0] exp_a, exp_b;
    int st0;
    for (int k = 0; k < 8; k++) begin
      exp_a[k*32 +: 32] = 32'h21 + 32'(k);
      exp_b[k*32 +: 32] = 32'(9 + k);
    end
    bus.m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h21 + 32'(i), i == 7);
    st0 = stalls;
    for (int i = 9; i <= 15; i++) send(32'(i), 1'b0);
    checks++; if (stalls !== st0) begin errors++; $display("FAIL bp_absorb stalls=%0d exp=%0d", stalls, st0); end
    bus.s_tvalid = 1'b1; bus.s_tdata = 32'd16; bus.s_tlast = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++; if (bus.s_tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready cyc=%0d got=%b exp=0", c, bus.s_tready); end
      checks++; if (bus.m_tdata !== exp_a) begin errors++; $display("FAIL bp_hold got=%h exp=%h", bus.m_tdata, exp_a); end
    end
    @(posedge aclk); #1;
    bus.m_tready = 1'b1;
    send(32'd16, 1'b1);
    checks++; if (bus.m_tdata !== exp_b) begin errors++; $display("FAIL bp_beat2 got=%h exp=%h", bus.m_tdata, exp_b); end
    checks++; if (bus.m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_beat2_valid got=%b exp=1", bus.m_tvalid); end
    checks++; if (beat_cnt !== 32'd2) begin errors++; $display("FAIL bp_cnt_a got=%0d exp=2", beat_cnt); end
    idle();
    @(posedge aclk); #1;
    checks++; if (beat_cnt !== 32'd3) begin errors++; $display("FAIL bp_cnt_b got=%0d exp=3", beat_cnt); end
  endtask

  task automatic test_short_frame();
    logic [255:0] exp_s, exp_n;
    exp_s = '0;
    exp_s[31:0] = 32'hA; exp_s[63:32] = 32'hB; exp_s[95:64] = 32'hC;
    for (int k = 0; k < 8; k++) exp_n[k*32 +: 32] = 32'h31 + 32'(k);
    bus.m_tready = 1'b1;
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    checks++; if (bus.m_tdata !== exp_s) begin errors++; $display("FAIL short_data got=%h exp=%h", bus.m_tdata, exp_s); end
    checks++; if (bus.m_tlast !== 1'b1) begin errors++; $display("FAIL short_last got=%b exp=1", bus.m_tlast); end
    checks++; if (err_short !== 1'b1) begin errors++; $display("FAIL short_err_hi got=%b exp=1", err_short); end
    idle();
    @(posedge aclk); #1;
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL short_err_lo got=%b exp=0", err_short); end
    for (int i = 0; i < 8; i++) send(32'h31 + 32'(i), i == 7);
    checks++; if (bus.m_tdata !== exp_n) begin errors++; $display("FAIL short_next got=%h exp=%h", bus.m_tdata, exp_n); end
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL short_next_err got=%b exp=0", err_short); end
    idle();
    @(posedge aclk); #1;
    checks++; if (beat_cnt !== 32'd5) begin errors++; $display("FAIL short_cnt got=%0d exp=5", beat_cnt); end
  endtask

  task automatic test_streaming();
    logic [255:0] exp;
    int st0;
    clear_mon();
    st0 = stalls;
    bus.m_tready = 1'b1;
    for (int i = 0; i < 64; i++) send(32'h100 + 32'(i), (i % 8) == 7);
    idle();
    repeat (2) @(posedge aclk); #1;
    checks++; if (stalls !== st0) begin errors++; $display("FAIL stream_stall got=%0d exp=%0d", stalls - st0, 0); end
    checks++; if (beat_q.size() !== 8) begin errors++; $display("FAIL stream_nbeats got=%0d exp=8", beat_q.size()); end
    checks++; if (beat_cnt !== 32'd13) begin errors++; $display("FAIL stream_cnt got=%0d exp=13", beat_cnt); end
    for (int b = 0; b < beat_q.size() && b < 8; b++) begin
      for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'h100 + 32'(b*8 + k);
      checks++; if (beat_q[b] !== exp) begin errors++; $display("FAIL stream_beat%0d got=%h exp=%h", b, beat_q[b], exp); end
      checks++; if (last_q[b] !== 1'b1) begin errors++; $display("FAIL stream_last%0d got=%b exp=1", b, last_q[b]); end
      if (b > 0) begin
        checks++; if (cyc_q[b] - cyc_q[b-1] !== 8) begin errors++; $display("FAIL stream_gap%0d got=%0d exp=8", b, cyc_q[b] - cyc_q[b-1]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'h10 + 32'(k);
    bus.m_tready = 1'b1;
    for (int i = 0; i < 5; i++) send(32'hE0 + 32'(i), 1'b0);
    idle();
    aresetn = 1'b0;
    @(negedge aclk);
    checks++; if (bus.s_tready !== 1'b0) begin errors++; $display("FAIL mrst_s_tready got=%b exp=0", bus.s_tready); end
    checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL mrst_cnt got=%0d exp=0", beat_cnt); end
    checks++; if (bus.m_tdata !== 256'd0) begin errors++; $display("FAIL mrst_data got=%h exp=0", bus.m_tdata); end
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    clear_mon();
    for (int i = 0; i < 8; i++) send(32'h10 + 32'(i), i == 7);
    idle();
    repeat (2) @(posedge aclk); #1;
    checks++; if (beat_q.size() !== 1) begin errors++; $display("FAIL mrst_nbeats got=%0d exp=1", beat_q.size()); end
    if (beat_q.size() > 0) begin
      checks++; if (beat_q[0] !== exp) begin errors++; $display("FAIL mrst_beat got=%h exp=%h", beat_q[0], exp); end
    end
    checks++; if (beat_cnt !== 32'd1) begin errors++; $display("FAIL mrst_cnt_after got=%0d exp=1", beat_cnt); end
  endtask

  task automatic test_drain_load();
    logic [255:0] exp;
    clear_mon();
    bus.m_tready = 1'b0;
    tog_en = 1'b1;
    for (int i = 0; i < 40; i++) send(32'h500 + 32'(i), (i % 8) == 7);
    idle();
    repeat (3) @(posedge aclk);
    tog_en = 1'b0;
    #2;
    bus.m_tready = 1'b1;
    repeat (3) @(posedge aclk); #1;
    checks++; if (beat_q.size() !== 5) begin errors++; $display("FAIL dl_nbeats got=%0d exp=5", beat_q.size()); end
    checks++; if (beat_cnt !== 32'd6) begin errors++; $display("FAIL dl_cnt got=%0d exp=6", beat_cnt); end
    for (int b = 0; b < beat_q.size() && b < 5; b++) begin
      for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'h500 + 32'(b*8 + k);
      checks++; if (beat_q[b] !== exp) begin errors++; $display("FAIL dl_beat%0d got=%h exp=%h", b, beat_q[b], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_streaming();
    test_reset_mid_frame();
    test_drain_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
